// File: rtl/crc_32.sv
// Byte-serial Ethernet CRC-32 (IEEE 802.3 FCS) generator/checker.
// Absorbs one byte per qualified clock and presents the complemented CRC
// byte-swapped, so the MAC shifts crc[31:24] out LSB-first first.
module crc_32 (
   input  logic        clk,
   input  logic        rst,
   input  logic        vld,
   input  logic [7:0]  data,
   output logic [31:0] crc
);

   localparam logic [31:0] POLY = 32'hEDB88320;
   localparam logic [31:0] INIT = 32'hFFFFFFFF;

   logic [31:0] r;
   logic [31:0] r_next;
   logic [31:0] f;

   // Reflected CRC-32 over one byte, bit 0 first; the loop unrolls into a
   // single-cycle XOR network so a byte can be absorbed every clock.
   function automatic logic [31:0] next_crc(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] t;
      logic        fb;
      t = c;
      for (int k = 0; k < 8; k++) begin
         fb = t[0] ^ d[k];
         t  = (t >> 1) ^ (fb ? POLY : 32'h0);
      end
      return t;
   endfunction

   // Next-state value: absorb data only when qualified, otherwise hold.
   always_comb begin
      r_next = r;
      if (vld) begin
         r_next = next_crc(r, data);
      end
   end

   // CRC register; reset restarts the frame asynchronously and beats vld.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r <= INIT;
      end else begin
         r <= r_next;
      end
   end

   // Final XOR and byte swap, derived from the register only.
   always_comb begin
      f   = ~r;
      crc = {f[7:0], f[15:8], f[23:16], f[31:24]};
   end

endmodule

// File: tb/tb_crc_32.sv
// Self-checking bench for crc_32: a table-driven CRC model over the queue of
// bytes absorbed since reset, compared on every falling edge, plus literal
// expectations for the standard check values.
module tb_crc_32;

   logic        clk;
   logic        rst;
   logic        vld;
   logic [7:0]  data;
   logic [31:0] crc;

   int checks = 0;
   int errors = 0;

   logic [31:0] tbl [256];
   logic [7:0]  absorbed [$];
   logic [7:0]  str9 [9];

   crc_32 dut (
      .clk  (clk),
      .rst  (rst),
      .vld  (vld),
      .data (data),
      .crc  (crc)
   );

   // 50 MHz reference clock
   initial clk = 1'b0;
   always #10 clk = ~clk;

   // Standard CRC-32 (final value, not swapped) of a byte queue, table-driven.
   function automatic logic [31:0] std_crc(input logic [7:0] q [$]);
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      foreach (q[i]) c = tbl[(c ^ {24'h0, q[i]}) & 32'hFF] ^ (c >> 8);
      return ~c;
   endfunction

   function automatic logic [31:0] swap32(input logic [31:0] v);
      return {v[7:0], v[15:8], v[23:16], v[31:24]};
   endfunction

   // Reference model: record the bytes the DUT should have absorbed.
   always @(posedge clk or posedge rst) begin
      if (rst) absorbed.delete();
      else if (vld) absorbed.push_back(data);
   end

   // Continuous compare against the model on every falling edge.
   always @(negedge clk) begin
      logic [31:0] exp;
      exp = swap32(std_crc(absorbed));
      checks++;
      if (crc !== exp) begin
         errors++;
         $display("FAIL model_cmp t=%0t crc=%h expected=%h", $time, crc, exp);
      end
   end

   task automatic chk(input string name, input logic [31:0] exp);
      checks++;
      if (crc !== exp) begin
         errors++;
         $display("FAIL %s crc=%h expected=%h", name, crc, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic send(input logic [7:0] b, input int gap);
      vld  = 1'b1;
      data = b;
      cyc();
      vld  = 1'b0;
      data = 8'($urandom);
      repeat (gap) cyc();
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
   endtask

   task automatic send_str9(input int gap);
      for (int i = 0; i < 9; i++) send(str9[i], gap);
   endtask

   initial begin
      logic [31:0] c;
      logic [31:0] fcs;
      logic [7:0]  frame [$];

      for (int n = 0; n < 256; n++) begin
         c = 32'(n);
         for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
         tbl[n] = c;
      end
      for (int i = 0; i < 9; i++) str9[i] = 8'h31 + 8'(i);

      // Pin the model itself against the published check value.
      frame.delete();
      foreach (str9[i]) frame.push_back(str9[i]);
      checks++;
      if (std_crc(frame) !== 32'hCBF43926) begin
         errors++;
         $display("FAIL model_check_value got=%h expected=cbf43926", std_crc(frame));
      end

      // Reset held with vld high: nothing absorbed.
      rst  = 1'b1;
      vld  = 1'b1;
      data = 8'hA5;
      #1;
      chk("reset_async_start", 32'h00000000);
      repeat (3) cyc();
      chk("reset_hold_vld", 32'h00000000);
      vld = 1'b0;
      rst = 1'b0;
      repeat (3) cyc();
      chk("idle_after_reset", 32'h00000000);

      // Single byte "a".
      send(8'h61, 2);
      chk("byte_61", 32'h43BEB7E8);

      // Asynchronous reset mid-cycle, no clock edge.
      rst = 1'b1;
      #1;
      chk("async_rst_midclk", 32'h00000000);
      cyc();
      rst = 1'b0;
      cyc();

      // "123456789" back to back.
      send_str9(0);
      cyc();
      chk("str9_consecutive", 32'h2639F4CB);
      repeat (5) cyc();
      chk("str9_hold", 32'h2639F4CB);

      // Same string, vld every 4th cycle.
      pulse_rst();
      send_str9(3);
      chk("str9_gapped", 32'h2639F4CB);

      // Single zero byte.
      pulse_rst();
      send(8'h00, 1);
      chk("byte_00", 32'h8DEF02D2);

      // 60-byte frame followed by its own FCS in wire order.
      pulse_rst();
      frame.delete();
      for (int i = 0; i < 60; i++) frame.push_back(8'((i * 37 + 11) ^ (i >> 2)));
      foreach (frame[i]) send(frame[i], (i % 3 == 0) ? 1 : 0);
      fcs = swap32(std_crc(frame));
      chk("frame60_fcs", fcs);
      send(fcs[31:24], 0);
      send(fcs[23:16], 0);
      send(fcs[15:8], 0);
      send(fcs[7:0], 0);
      chk("frame60_residue", 32'h1CDF4421);

      // Abort mid-frame, then full string.
      pulse_rst();
      for (int i = 0; i < 5; i++) send(str9[i], 0);
      pulse_rst();
      send_str9(0);
      chk("abort_restart", 32'h2639F4CB);

      // rst and vld on the same edge: byte ignored.
      rst  = 1'b1;
      vld  = 1'b1;
      data = 8'h61;
      cyc();
      rst = 1'b0;
      vld = 1'b0;
      cyc();
      chk("rst_vld_same_edge", 32'h00000000);

      repeat (2) cyc();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
